// File: rtl/ffm_pkg.sv
// ---------------------------------------------------------------------------
// ffm_pkg
// Shared definitions for the finite-field multiplier (ffm) cluster.
//   FE_W            : field element width (255 bits)
//   P               : field modulus 2^255 - 19
//   ffm_arb_state_t : state encoding of the ffm_arbiter control FSM
// ---------------------------------------------------------------------------
package ffm_pkg;

    localparam int FE_W = 255;

    // 2^255 - 1 is all ones; subtracting 18 more leaves ...FFED in the low byte.
    localparam logic [FE_W-1:0] P = {{(FE_W-5){1'b1}}, 5'b01101};

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ffm_arb_state_t;

endpackage

// File: rtl/ffm_arb_pick.sv
// ---------------------------------------------------------------------------
// ffm_arb_pick
// Combinational winner picker for ffm_arbiter.
//   req   in  NREQ : request levels
//   ptr   in  PW   : round-robin start position
//   found out 1    : at least one request is high
//   idx   out PW   : index of the winning requester (0 when found is low)
// Build option:
//   FFM_ARB_FIXED_PRIO_EN : lowest-index request wins, ptr is ignored.
//   (default)             : first high request at or after ptr, wrapping.
// ---------------------------------------------------------------------------
module ffm_arb_pick
    import ffm_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

`ifdef FFM_ARB_FIXED_PRIO_EN

    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scan from the top down so the lowest-index high request is the last
    // one written and therefore the winner.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[PW'(k)]) begin
                found = 1'b1;
                idx   = PW'(k);
            end
        end
    end

`else

    // Visit requesters in the order ptr, ptr+1, ... with wrap-around and
    // keep the first high one. The modulo keeps non-power-of-two NREQ legal.
    always_comb begin
        int          cand_i;
        logic [PW-1:0] cand;
        found  = 1'b0;
        idx    = '0;
        cand_i = 0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_i = (int'(ptr) + k) % NREQ;
            cand   = PW'(cand_i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

`endif

endmodule

// File: rtl/ffm_arbiter.sv
// ---------------------------------------------------------------------------
// ffm_arbiter
// Shares one external ffm multiplier between NREQ requesters. A winner's
// operands are registered onto mul_a/mul_b, held for the whole
// multiplication, and the result is returned on res with a done pulse.
//   clk, rst        : clock, synchronous active-high reset
//   req   in  NREQ  : request levels (operands valid while high)
//   op_a  in  NREQ*W: packed operand A, requester i at [i*W +: W]
//   op_b  in  NREQ*W: packed operand B, requester i at [i*W +: W]
//   gnt   out NREQ  : one-cycle pulse, operands of that requester captured
//   done  out NREQ  : one-cycle pulse, res valid for that requester
//   res   out W     : shared result bus, held until the next done
//   busy  out 1     : multiplication in flight
//   mul_start out 1 : start pulse to ffm
//   mul_a, mul_b    : operands to ffm, stable from start to valid
//   mul_result in W : result from ffm
//   mul_valid  in 1 : one-cycle result valid from ffm
// Build option:
//   FFM_ARB_FIXED_PRIO_EN : fixed priority (lowest index wins), the
//                           round-robin pointer is never advanced.
// ---------------------------------------------------------------------------
module ffm_arbiter
    import ffm_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = FE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      res,
    output logic              busy,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_result,
    input  logic              mul_valid
);

    localparam int PW = $clog2(NREQ);

    ffm_arb_state_t state, state_next;

    logic [PW-1:0]   ptr, ptr_next;
    logic [PW-1:0]   owner, owner_next;
    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] gnt_next, done_next;
    logic            start_next;
    logic            load_ops;
    logic            load_res;
    logic [W-1:0]    a_sel, b_sel;

    ffm_arb_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign a_sel = op_a[pick_idx*W +: W];
    assign b_sel = op_b[pick_idx*W +: W];
    assign busy  = (state == WAIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and registered-output decode. gnt/mul_start/done are
    // computed here one cycle early and registered, so they appear as clean
    // single-cycle pulses. req is only looked at in IDLE.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        gnt_next   = '0;
        done_next  = '0;
        start_next = 1'b0;
        load_ops   = 1'b0;
        load_res   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_next         = pick_idx;
                    gnt_next[pick_idx] = 1'b1;
                    start_next         = 1'b1;
                    load_ops           = 1'b1;
                    state_next         = WAIT;
                end
            end
            WAIT: begin
                if (mul_valid) begin
                    load_res        = 1'b1;
                    done_next[owner] = 1'b1;
                    state_next      = IDLE;
`ifndef FFM_ARB_FIXED_PRIO_EN
                    ptr_next = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and handshake registers. mul_a/mul_b only load on a grant,
    // which keeps them frozen while ffm works even if op_a/op_b change.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            done      <= '0;
            res       <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            ptr       <= ptr_next;
            owner     <= owner_next;
            gnt       <= gnt_next;
            done      <= done_next;
            mul_start <= start_next;
            if (load_ops) begin
                mul_a <= a_sel;
                mul_b <= b_sel;
            end
            if (load_res) begin
                res <= mul_result;
            end
        end
    end

endmodule

// File: tb/tb_ffm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ffm_arbiter
// Self-checking bench for ffm_arbiter with a behavioural ffm model
// (random latency, modular product) and scenario tasks.
// Honours FFM_ARB_FIXED_PRIO_EN for the expected grant order.
// ---------------------------------------------------------------------------
module tb_ffm_arbiter;
    import ffm_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = FE_W;
`ifdef FFM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a, op_b;
    logic [NREQ-1:0]   gnt, done;
    logic [W-1:0]      res;
    logic              busy, mul_start;
    logic [W-1:0]      mul_a, mul_b, mul_result;
    logic              mul_valid;

    logic              ffm_valid, spur_valid;
    logic [W-1:0]      ffm_result, spur_result;

    int vectors      = 0;
    int miscompares  = 0;
    int force_lat    = 0;
    int last_lat     = 0;
    logic [W-1:0] last_res_exp;
    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    assign mul_valid  = ffm_valid | spur_valid;
    assign mul_result = spur_valid ? spur_result : ffm_result;

    ffm_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .done       (done),
        .res        (res),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_valid  (mul_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(prod % {{W{1'b0}}, P});
    endfunction

    function automatic logic [W-1:0] rand_fe();
        logic [255:0] r;
        logic [W-1:0] v;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        v = r[W-1:0];
        if (v >= P) v = v - P;
        return v;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*W +: W] = opa[i];
            op_b[i*W +: W] = opb[i];
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Behavioural ffm: after a start it waits a random number of cycles,
    // checking that the operands do not move, then returns a*b mod P.
    // It gives up silently once the arbiter leaves WAIT (reset).
    initial begin
        logic [W-1:0] fa, fb;
        int lat;
        bit aborted;
        ffm_valid  = 1'b0;
        ffm_result = '0;
        forever begin
            @(posedge clk); #1;
            ffm_valid = 1'b0;
            if (mul_start === 1'b1) begin
                fa      = mul_a;
                fb      = mul_b;
                lat     = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
                aborted = 1'b0;
                for (int c = 0; c < lat; c++) begin
                    @(posedge clk); #1;
                    if (busy !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    vectors++;
                    if (mul_a !== fa || mul_b !== fb) begin
                        miscompares++;
                        $display("[TB] FAIL op_stable: mul_a=%0h mul_b=%0h expected %0h %0h", mul_a, mul_b, fa, fb);
                    end
                end
                if (!aborted) begin
                    ffm_valid  = 1'b1;
                    ffm_result = mulmod(fa, fb);
                    last_lat   = lat;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (gnt !== '0)       begin miscompares++; $display("[TB] FAIL rst_gnt: got %0h expected 0", gnt); end
        vectors++; if (done !== '0)      begin miscompares++; $display("[TB] FAIL rst_done: got %0h expected 0", done); end
        vectors++; if (res !== '0)       begin miscompares++; $display("[TB] FAIL rst_res: got %0h expected 0", res); end
        vectors++; if (mul_start !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_start: got %0b expected 0", mul_start); end
        vectors++; if (mul_a !== '0)     begin miscompares++; $display("[TB] FAIL rst_mul_a: got %0h expected 0", mul_a); end
        vectors++; if (mul_b !== '0)     begin miscompares++; $display("[TB] FAIL rst_mul_b: got %0h expected 0", mul_b); end
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int k;
        bit seen;
        opa[1] = W'(2);
        opb[1] = W'(3);
        pack_ops();
        @(posedge clk); #1;
        req = 4'b0010;
        @(posedge clk); #1;
        vectors++; if (gnt !== 4'b0010)   begin miscompares++; $display("[TB] FAIL single_gnt: got %0b expected 0010", gnt); end
        vectors++; if (mul_start !== 1'b1) begin miscompares++; $display("[TB] FAIL single_start: got %0b expected 1", mul_start); end
        vectors++; if (busy !== 1'b1)     begin miscompares++; $display("[TB] FAIL single_busy: got %0b expected 1", busy); end
        vectors++; if (mul_a !== W'(2) || mul_b !== W'(3)) begin miscompares++; $display("[TB] FAIL single_ops: got %0h %0h expected 2 3", mul_a, mul_b); end
        req    = '0;
        opa[1] = rand_fe();
        opb[1] = rand_fe();
        pack_ops();
        seen = 1'b0;
        for (k = 2; k < 40; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (gnt !== '0) begin miscompares++; $display("[TB] FAIL single_extra_gnt: got %0b expected 0", gnt); end
            if (done !== '0) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("[TB] FAIL single_timeout: done got 0 expected 0010");
        end else begin
            vectors++; if (done !== 4'b0010) begin miscompares++; $display("[TB] FAIL single_done: got %0b expected 0010", done); end
            vectors++; if (res !== W'(6))    begin miscompares++; $display("[TB] FAIL single_res: got %0h expected 6", res); end
            vectors++; if (k != last_lat + 2) begin miscompares++; $display("[TB] FAIL single_latency: got %0d expected %0d", k, last_lat + 2); end
            last_res_exp = W'(6);
            @(posedge clk); #1;
            vectors++; if (done !== '0 || res !== W'(6)) begin miscompares++; $display("[TB] FAIL single_hold: done=%0b res=%0h expected 0 6", done, res); end
        end
    endtask

    task automatic test_max();
        bit seen;
        force_lat = 6;
        opa[0] = P - 1;
        opb[0] = P - 1;
        pack_ops();
        @(posedge clk); #1;
        req = 4'b0001;
        @(posedge clk); #1;
        vectors++; if (gnt !== 4'b0001 || mul_a !== P - 1 || mul_b !== P - 1) begin
            miscompares++; $display("[TB] FAIL max_gnt: gnt=%0b mul_a=%0h expected 0001 %0h", gnt, mul_a, P - 1);
        end
        req    = '0;
        opa[0] = rand_fe();
        opb[0] = rand_fe();
        pack_ops();
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done !== '0) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen || done !== 4'b0001 || res !== W'(1)) begin
            miscompares++; $display("[TB] FAIL max_res: done=%0b res=%0h expected 0001 1", done, res);
        end
        last_res_exp = W'(1);
        force_lat = 0;
    endtask

    task automatic test_held_requests(input logic [NREQ-1:0] mask, input bit spec_ops, input int nops);
        int exp_w [$];
        int ptr_m, w, c_i, gcount, dcount, last_done;
        logic [W-1:0] exp_res;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            if (spec_ops) begin
                opa[i] = W'(i + 1);
                opb[i] = W'(i + 5);
            end else begin
                opa[i] = rand_fe();
                opb[i] = rand_fe();
            end
        end
        pack_ops();
        ptr_m = 0;
        for (int n = 0; n < nops; n++) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                c_i = (ptr_m + k) % NREQ;
                if (w < 0 && mask[c_i]) w = c_i;
            end
            ptr_m = FIXED ? 0 : (w + 1) % NREQ;
            exp_w.push_back(w);
        end
        req       = mask;
        gcount    = 0;
        dcount    = 0;
        last_done = -100;
        for (int c = 0; c < 40 * nops && dcount < nops; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (gnt !== '0 && done !== '0) begin
                miscompares++; $display("[TB] FAIL held_overlap: gnt=%0b done=%0b expected not both", gnt, done);
            end
            if (gnt !== '0) begin
                if (gcount >= nops) begin
                    vectors++; miscompares++;
                    $display("[TB] FAIL held_extra_gnt: got %0b expected none", gnt);
                end else begin
                    vectors++;
                    if (gnt !== (NREQ'(1) << exp_w[gcount])) begin
                        miscompares++; $display("[TB] FAIL held_gnt: got %0b expected index %0d", gnt, exp_w[gcount]);
                    end
                    vectors++;
                    if (mul_start !== 1'b1) begin
                        miscompares++; $display("[TB] FAIL held_start: got %0b expected 1", mul_start);
                    end
                    vectors++;
                    if (mul_a !== opa[exp_w[gcount]] || mul_b !== opb[exp_w[gcount]]) begin
                        miscompares++; $display("[TB] FAIL held_ops: got %0h %0h expected %0h %0h", mul_a, mul_b, opa[exp_w[gcount]], opb[exp_w[gcount]]);
                    end
                    if (gcount > 0) begin
                        vectors++;
                        if (c != last_done + 1) begin
                            miscompares++; $display("[TB] FAIL held_gap: gnt cycle %0d expected %0d", c, last_done + 1);
                        end
                    end
                end
                gcount++;
            end
            if (done !== '0) begin
                if (dcount < nops) begin
                    vectors++;
                    if (done !== (NREQ'(1) << exp_w[dcount])) begin
                        miscompares++; $display("[TB] FAIL held_done: got %0b expected index %0d", done, exp_w[dcount]);
                    end
                    exp_res = mulmod(opa[exp_w[dcount]], opb[exp_w[dcount]]);
                    vectors++;
                    if (res !== exp_res) begin
                        miscompares++; $display("[TB] FAIL held_res: got %0h expected %0h", res, exp_res);
                    end
                    last_res_exp = exp_res;
                end
                last_done = c;
                dcount++;
                if (dcount == nops) req = '0;
            end
        end
        req = '0;
        vectors++;
        if (dcount < nops) begin
            miscompares++; $display("[TB] FAIL held_timeout: done count %0d expected %0d", dcount, nops);
        end
        repeat (4) begin
            @(posedge clk); #1;
            vectors++;
            if (gnt !== '0 || busy !== 1'b0) begin
                miscompares++; $display("[TB] FAIL held_quiet: gnt=%0b busy=%0b expected 0 0", gnt, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [W-1:0] exp_res;
        force_lat = 12;
        opa[3] = rand_fe();
        opb[3] = rand_fe();
        pack_ops();
        @(posedge clk); #1;
        req  = 4'b1000;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (gnt !== '0) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("[TB] FAIL midrst_gnt: got 0 expected 1000"); end
        req = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (gnt !== '0 || done !== '0 || res !== '0 || mul_start !== 1'b0 ||
            mul_a !== '0 || mul_b !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_clear: gnt=%0b done=%0b res=%0h start=%0b busy=%0b expected all 0", gnt, done, res, mul_start, busy);
        end
        force_lat = 0;
        repeat (16) begin
            @(posedge clk); #1;
            vectors++;
            if (done !== '0) begin miscompares++; $display("[TB] FAIL midrst_done: got %0b expected 0", done); end
        end
        opa[2] = rand_fe();
        opb[2] = rand_fe();
        pack_ops();
        exp_res = mulmod(opa[2], opb[2]);
        req = 4'b0100;
        @(posedge clk); #1;
        vectors++;
        if (gnt !== 4'b0100) begin miscompares++; $display("[TB] FAIL midrst_regnt: got %0b expected 0100", gnt); end
        req  = '0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done !== '0) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen || done !== 4'b0100 || res !== exp_res) begin
            miscompares++; $display("[TB] FAIL midrst_after: done=%0b res=%0h expected 0100 %0h", done, res, exp_res);
        end
        last_res_exp = exp_res;
    endtask

    task automatic test_spurious();
        @(posedge clk); #1;
        req         = '0;
        spur_result = ~last_res_exp;
        spur_valid  = 1'b1;
        @(posedge clk); #1;
        spur_valid = 1'b0;
        repeat (4) begin
            vectors++;
            if (done !== '0 || res !== last_res_exp || busy !== 1'b0) begin
                miscompares++; $display("[TB] FAIL spurious: done=%0b res=%0h busy=%0b expected 0 %0h 0", done, res, busy, last_res_exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst          = 1'b1;
        req          = '0;
        op_a         = '0;
        op_b         = '0;
        spur_valid   = 1'b0;
        spur_result  = '0;
        last_res_exp = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        test_reset();
        test_single();
        test_max();
        test_held_requests(4'b0101, 1'b0, 4);
        test_held_requests(4'b1111, 1'b1, 4);
        test_held_requests(4'(($urandom_range(1, 15))), 1'b0, 6);
        test_reset_mid();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
